button_event_gen: RTL

BUTTON_EVENT_GEN -- requirements
Module: button_event_gen

---
 rtl/button_event_gen_pkg.sv | 15 +
 rtl/button_event_gen_if.sv | 33 +++
 rtl/button_event_gen_edge_detect.sv | 24 ++
 rtl/button_event_gen.sv | 124 ++++++++++++
 4 files changed

// File: rtl/button_event_gen_pkg.sv
// Shared types and default timing constants for the button event generator.
// Holds the FSM state encoding used by button_event_gen.
package button_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHORT = 2'd1,
        ST_LONG  = 2'd2
    } btn_state_t;

    localparam int LONG_CYCLES_DEF   = 1000;
    localparam int REPEAT_CYCLES_DEF = 250;
    localparam int CNT_W_DEF         = 16;

endpackage

// File: rtl/button_event_gen_if.sv
// Signal bundle between a button source and the event generator.
// master drives the button level, slave produces the event strobes.
interface button_event_gen_if;

    logic db_in;
    logic press_pulse;
    logic release_pulse;
    logic click_pulse;
    logic long_pulse;
    logic repeat_pulse;
    logic held;

    modport master (
        output db_in,
        input  press_pulse,
        input  release_pulse,
        input  click_pulse,
        input  long_pulse,
        input  repeat_pulse,
        input  held
    );

    modport slave (
        input  db_in,
        output press_pulse,
        output release_pulse,
        output click_pulse,
        output long_pulse,
        output repeat_pulse,
        output held
    );

endinterface

// File: rtl/button_event_gen_edge_detect.sv
// Press/release edge detector on the debounced button level.
// Strobes are combinational; the caller registers them.
module edge_detect #(
    parameter logic ACTIVE_LEVEL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_din,
    output logic o_rise,
    output logic o_fall
);

    logic r_prev;

    // Previous level starts "not pressed" so a held button reports a press
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_prev <= ~ACTIVE_LEVEL;
        else       r_prev <= i_din;
    end

    assign o_rise = (i_din == ACTIVE_LEVEL) && (r_prev != ACTIVE_LEVEL);
    assign o_fall = (i_din != ACTIVE_LEVEL) && (r_prev == ACTIVE_LEVEL);

endmodule

// File: rtl/button_event_gen.sv
// Button event generator: press, release, click, long-press and auto-repeat.
// One hold counter is shared by the long-press and repeat phases.
module button_event_gen
    import button_pkg::*;
#(
    parameter int   LONG_CYCLES   = LONG_CYCLES_DEF,
    parameter int   REPEAT_CYCLES = REPEAT_CYCLES_DEF,
    parameter int   CNT_W         = CNT_W_DEF,
    parameter logic ACTIVE_LEVEL  = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    button_event_gen_if.slave  bif
);

    // Counter value in the cycle before the event strobe is due
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    logic             w_rise;
    logic             w_fall;
    btn_state_t       r_state;
    btn_state_t       w_state_nx;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nx;
    logic             r_press,   w_press_nx;
    logic             r_release, w_release_nx;
    logic             r_click,   w_click_nx;
    logic             r_long,    w_long_nx;
    logic             r_repeat,  w_repeat_nx;
    logic             r_held,    w_held_nx;

    edge_detect #(
        .ACTIVE_LEVEL (ACTIVE_LEVEL)
    ) u_edge (
        .clk    (clk),
        .reset  (reset),
        .i_din  (bif.db_in),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    // State, counter and registered event strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_click   <= 1'b0;
            r_long    <= 1'b0;
            r_repeat  <= 1'b0;
            r_held    <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_press   <= w_press_nx;
            r_release <= w_release_nx;
            r_click   <= w_click_nx;
            r_long    <= w_long_nx;
            r_repeat  <= w_repeat_nx;
            r_held    <= w_held_nx;
        end
    end

    // Next state and strobes; a release always beats long/repeat
    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_press_nx   = 1'b0;
        w_release_nx = 1'b0;
        w_click_nx   = 1'b0;
        w_long_nx    = 1'b0;
        w_repeat_nx  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_nx = ST_SHORT;
                    w_cnt_nx   = '0;
                    w_press_nx = 1'b1;
                end
            end
            ST_SHORT: begin
                if (w_fall) begin
                    w_state_nx   = ST_IDLE;
                    w_cnt_nx     = '0;
                    w_release_nx = 1'b1;
                    w_click_nx   = 1'b1;
                end else if (r_cnt == LONG_LAST) begin
                    w_state_nx = ST_LONG;
                    w_cnt_nx   = '0;
                    w_long_nx  = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            ST_LONG: begin
                if (w_fall) begin
                    w_state_nx   = ST_IDLE;
                    w_cnt_nx     = '0;
                    w_release_nx = 1'b1;
                end else if (r_cnt == REP_LAST) begin
                    w_cnt_nx    = '0;
                    w_repeat_nx = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_cnt_nx   = '0;
            end
        endcase
        w_held_nx = (w_state_nx != ST_IDLE);
    end

    assign bif.press_pulse   = r_press;
    assign bif.release_pulse = r_release;
    assign bif.click_pulse   = r_click;
    assign bif.long_pulse    = r_long;
    assign bif.repeat_pulse  = r_repeat;
    assign bif.held          = r_held;

endmodule
